// File: rtl/match_controller.sv
// Match sequencer for the volleyball game: frame tick generation, physics gating,
// scoring, win-target selection, serve alternation, pause and win-by-two handling.
module match_controller #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned FRAME_HZ     = 60,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned N_MODES      = 4,
  parameter int unsigned WIN_BASE     = 3,
  parameter int unsigned WIN_STEP     = 2,
  parameter int unsigned WIN_BY_TWO   = 1,
  parameter int unsigned SERVE_FRAMES = 30,
  parameter int unsigned POINT_FRAMES = 60,
  localparam int unsigned MODE_W      = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               start_pulse,
  input  logic               pause_pulse,
  input  logic               rally_over,
  input  logic [1:0]         rally_winner,
  output logic [2:0]         state,
  output logic               frame_tick,
  output logic               physic_en,
  output logic               load_serve,
  output logic               serve_side,
  output logic [MODE_W-1:0]  mode,
  output logic [SCORE_W-1:0] win_score,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         match_winner
);

  localparam int unsigned FRAME_DIV = CLK_HZ / FRAME_HZ;
  localparam int unsigned CNT_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned MAX_SCORE = (1 << SCORE_W) - 1;
  localparam int unsigned CD_MAX    = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned CD_W      = (CD_MAX > 1) ? $clog2(CD_MAX + 1) : 1;
  localparam int unsigned SC_W      = SCORE_W + 1;

  localparam logic [2:0] ST_SETUP  = 3'd0;
  localparam logic [2:0] ST_SERVE  = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_PAUSED = 3'd3;
  localparam logic [2:0] ST_POINT  = 3'd4;
  localparam logic [2:0] ST_OVER   = 3'd5;

  // Win target for a mode, clipped to the largest representable score.
  function automatic logic [SCORE_W-1:0] win_of(input logic [MODE_W-1:0] m);
    int unsigned t;
    t = WIN_BASE + 32'(m) * WIN_STEP;
    if (t > MAX_SCORE) t = MAX_SCORE;
    return SCORE_W'(t);
  endfunction

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               eval_q, eval_d;
  logic [2:0]         state_d;
  logic [MODE_W-1:0]  mode_d;
  logic [SCORE_W-1:0] p1_d, p2_d;
  logic               serve_d;
  logic [1:0]         winner_d;
  logic               load_serve_d;
  logic               tick_d;
  logic               p1_wins, p2_wins;
  logic               valid_rally;

  // Physics only advances on frame ticks while the rally is live.
  assign physic_en = frame_tick && (state == ST_PLAY);

  // Free-running frame divider; tick is registered so it lines up with cnt == FRAME_DIV-1.
  always_comb begin
    cnt_d  = (cnt_q == CNT_W'(FRAME_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == CNT_W'(FRAME_DIV - 1));
  end

  // Match-end check: target reached plus lead of two, unless lead rule disabled or score saturated.
  always_comb begin
    p1_wins = (p1_score >= win_score) &&
              ((WIN_BY_TWO == 0) ||
               ({1'b0, p1_score} >= {1'b0, p2_score} + SC_W'(2)) ||
               (p1_score == SCORE_W'(MAX_SCORE)));
    p2_wins = (p2_score >= win_score) &&
              ((WIN_BY_TWO == 0) ||
               ({1'b0, p2_score} >= {1'b0, p1_score} + SC_W'(2)) ||
               (p2_score == SCORE_W'(MAX_SCORE)));
    valid_rally = rally_over && ((rally_winner == 2'd1) || (rally_winner == 2'd2));
  end

  // Next-state and next-output logic for the match sequencer.
  always_comb begin
    state_d  = state;
    mode_d   = mode;
    p1_d     = p1_score;
    p2_d     = p2_score;
    serve_d  = serve_side;
    winner_d = match_winner;
    cd_d     = cd_q;
    eval_d   = 1'b0;

    case (state)
      ST_SETUP: begin
        if (btn_up && !btn_down && (mode != MODE_W'(N_MODES - 1))) begin
          mode_d = mode + MODE_W'(1);
        end else if (btn_down && !btn_up && (mode != '0)) begin
          mode_d = mode - MODE_W'(1);
        end
        if (start_pulse) begin
          state_d  = ST_SERVE;
          p1_d     = '0;
          p2_d     = '0;
          serve_d  = 1'b0;
          winner_d = 2'd0;
          cd_d     = CD_W'(SERVE_FRAMES);
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cd_q <= CD_W'(1)) state_d = ST_PLAY;
          else                  cd_d    = cd_q - CD_W'(1);
        end
      end
      ST_PLAY: begin
        // A grounded ball takes priority over a simultaneous pause request.
        if (valid_rally) begin
          state_d = ST_POINT;
          eval_d  = 1'b1;
          cd_d    = CD_W'(POINT_FRAMES);
          if (rally_winner == 2'd1) begin
            if (p1_score != SCORE_W'(MAX_SCORE)) p1_d = p1_score + SCORE_W'(1);
            serve_d = 1'b0;
          end else begin
            if (p2_score != SCORE_W'(MAX_SCORE)) p2_d = p2_score + SCORE_W'(1);
            serve_d = 1'b1;
          end
        end else if (pause_pulse) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_pulse) state_d = ST_PLAY;
      end
      ST_POINT: begin
        // First POINT cycle sees the updated score and decides whether the match is over.
        if (eval_q) begin
          if (p1_wins) begin
            state_d  = ST_OVER;
            winner_d = 2'd1;
          end else if (p2_wins) begin
            state_d  = ST_OVER;
            winner_d = 2'd2;
          end
        end else if (frame_tick) begin
          if (cd_q <= CD_W'(1)) begin
            state_d = ST_SERVE;
            cd_d    = CD_W'(SERVE_FRAMES);
          end else begin
            cd_d = cd_q - CD_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_pulse) state_d = ST_SETUP;
      end
      default: state_d = ST_SETUP;
    endcase

    load_serve_d = (state_d == ST_SERVE) && (state != ST_SERVE);
  end

  // State and registered outputs; synchronous reset abandons the match in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_SETUP;
      mode         <= '0;
      win_score    <= win_of('0);
      p1_score     <= '0;
      p2_score     <= '0;
      serve_side   <= 1'b0;
      match_winner <= 2'd0;
      load_serve   <= 1'b0;
      frame_tick   <= 1'b0;
      cnt_q        <= '0;
      cd_q         <= '0;
      eval_q       <= 1'b0;
    end else begin
      state        <= state_d;
      mode         <= mode_d;
      win_score    <= win_of(mode_d);
      p1_score     <= p1_d;
      p2_score     <= p2_d;
      serve_side   <= serve_d;
      match_winner <= winner_d;
      load_serve   <= load_serve_d;
      frame_tick   <= tick_d;
      cnt_q        <= cnt_d;
      cd_q         <= cd_d;
      eval_q       <= eval_d;
    end
  end

endmodule
